wb_cmd_master: RTL

- Single-outstanding Wishbone classic master that turns simple valid/ready command requests into Wishbone cycles on an EF_*_WB peripheral wrapper.
- Returns read data and an error/timeout status on a valid/ready response channel.
- Sits directly upstream of the Wishbone wrapper in IP test tops and SoC glue, and drives its adr_i/dat_i/sel_i/cyc_i/stb_i/we_i inputs.

---
 rtl/wb_cmd_master_if.sv | 42 ++++
 rtl/wb_cmd_master.sv | 136 +++++++++++++
 2 files changed

// File: rtl/wb_cmd_master_if.sv
// Bundle of the command/response channels and the Wishbone classic bus for wb_cmd_master.
// The master modport is the command master's view; the slave modport is the view from the opposite side.
interface wb_cmd_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_sel;
    logic        req_we;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic [3:0]  sel_o;
    logic        we_o;
    logic        cyc_o;
    logic        stb_o;
    logic        ack_i;

    modport master (
        input  req_valid, req_addr, req_wdata, req_sel, req_we,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
        input  dat_i, ack_i
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_sel, req_we,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
        output dat_i, ack_i
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic master: one valid/ready command becomes one bus cycle,
// and the result (read data or timeout error) comes back on a valid/ready response channel.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned TO_W     = 8,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic clk_i,
    input  logic rst_i,
    wb_cmd_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value seen in the last strobe cycle before a timeout abort.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [3:0]      sel_q, sel_d;
    logic            we_q, we_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    adr_d   = bus.req_addr;
                    dat_d   = bus.req_wdata;
                    sel_d   = bus.req_sel;
                    we_d    = bus.req_we;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                cnt_d = cnt_q + 1'b1;
                // An ack in the same cycle as the timeout still counts as success.
                if (bus.ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_rdata_d = we_q ? 32'd0 : bus.dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (timeout_hit) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_rdata_d = ERR_DATA;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.adr_o     = adr_q;
    assign bus.dat_o     = dat_q;
    assign bus.sel_o     = sel_q;
    assign bus.we_o      = we_q;
    assign bus.cyc_o     = cyc_q;
    assign bus.stb_o     = stb_q;

endmodule
